// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin arbiter that gives two requesters (port 0 for
// instruction fetch, port 1 for load/store) access to one single-port memory.
// The memory has asynchronous read and synchronous write. Each access holds
// the memory for a fixed number of cycles. Read data comes back in a
// registered word, together with a one-cycle valid pulse for the port that
// issued the access.
module memory_arbiter #(
  parameter int ADDR_SIZE   = 5,
  parameter int WORD_SIZE   = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 m0_req_i,
  input  logic [ADDR_SIZE-1:0] m0_addr_i,
  input  logic [WORD_SIZE-1:0] m0_data_i,
  input  logic                 m0_wen_i,
  output logic                 m0_gnt_o,
  output logic                 m0_rvalid_o,
  output logic [WORD_SIZE-1:0] m0_rdata_o,
  input  logic                 m1_req_i,
  input  logic [ADDR_SIZE-1:0] m1_addr_i,
  input  logic [WORD_SIZE-1:0] m1_data_i,
  input  logic                 m1_wen_i,
  output logic                 m1_gnt_o,
  output logic                 m1_rvalid_o,
  output logic [WORD_SIZE-1:0] m1_rdata_o,
  output logic [ADDR_SIZE-1:0] mem_addr_o,
  output logic [WORD_SIZE-1:0] mem_data_o,
  output logic                 mem_wen_o,
  input  logic [WORD_SIZE-1:0] mem_data_i
);

  // The counter is always at least one bit wide, so WAIT_STATES=0 still
  // gives a legal register.
  localparam int CNT_W = ($clog2(WAIT_STATES + 1) > 1) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t               state_q;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0] data_q;
  logic                 wen_q;
  logic                 id_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 last_q;
  logic [WORD_SIZE-1:0] rdata_q;
  logic [1:0]           rvalid_q;

  logic win_id;
  logic grant;
  logic final_cyc;

  // Pick the winner and flag a grant and the last BUSY cycle. Under
  // contention the port that was not served last wins.
  always_comb begin
    win_id = m1_req_i;
    if (m0_req_i && m1_req_i) begin
      win_id = ~last_q;
    end
    grant     = (state_q == IDLE) && (m0_req_i || m1_req_i);
    final_cyc = (state_q == BUSY) && (cnt_q == '0);
  end

  // Grants are forced low while reset is held, so every output reads 0 during reset.
  assign m0_gnt_o    = rst_ni & grant & ~win_id;
  assign m1_gnt_o    = rst_ni & grant &  win_id;
  assign mem_wen_o   = final_cyc & wen_q;
  assign mem_addr_o  = addr_q;
  assign mem_data_o  = data_q;
  assign m0_rvalid_o = rvalid_q[0];
  assign m1_rvalid_o = rvalid_q[1];
  assign m0_rdata_o  = rdata_q;
  assign m1_rdata_o  = rdata_q;

  // Access sequencer: latch the command in IDLE, count wait states in BUSY,
  // then capture read data and pulse valid for the port that issued the access.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      wen_q    <= 1'b0;
      id_q     <= 1'b0;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      rdata_q  <= '0;
      rvalid_q <= 2'b00;
    end else begin
      rvalid_q <= 2'b00;
      case (state_q)
        IDLE: begin
          if (grant) begin
            addr_q  <= win_id ? m1_addr_i : m0_addr_i;
            data_q  <= win_id ? m1_data_i : m0_data_i;
            wen_q   <= win_id ? m1_wen_i  : m0_wen_i;
            id_q    <= win_id;
            cnt_q   <= CNT_LOAD;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            // Read data is taken before the write edge, so a write returns the old word.
            rdata_q        <= mem_data_i;
            rvalid_q[id_q] <= 1'b1;
            last_q         <= id_q;
            state_q        <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
